// File: rtl/pipeline_fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_fetch_queue_pkg
//  Description : Shared definitions for the fetch stage: default widths,
//                NOP encoding and run-state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_fetch_queue_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int INSTR_W_DEF = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Run state of the fetch unit
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } run_state_e;

endpackage : pipeline_fetch_queue_pkg
`default_nettype wire

// File: rtl/pipeline_fetch_queue_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_fifo
//  Description : DEPTH-entry synchronous FIFO with single-cycle flush.
//                Head entry is read straight out of storage (no bypass), so
//                a pushed entry becomes visible on the cycle after the push.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                push_i/wdata_i  - enqueue request and data
//                pop_i           - dequeue head (ignored when empty)
//                flush_i         - drop all entries (wins over push/pop)
//                rdata_o         - head entry (zero while empty)
//                count_o/full_o/empty_o - occupancy status
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             pop_ok;
    logic             push_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;

    // A push into a full FIFO is only legal when the head leaves the same cycle
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; validity is tracked by count alone
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule : pipeline_fifo
`default_nettype wire

// File: rtl/pipeline_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_fetch_queue
//  Description : Fetch stage owning the PC and an instruction queue between
//                instruction memory and decode. Supports start-address load,
//                branch/jump redirect with flush, and halt.
//  Ports       : clk, rst_n                  - clock, async active-low reset
//                start_valid/start_addr      - load PC, flush, enter RUN
//                redirect_valid/redirect_addr- taken branch, flush, new PC
//                halt                        - stop fetching
//                imem_addr/imem_req/imem_rdata - combinational imem interface
//                deq_valid/deq_ready/deq_instr/deq_pc_plus4 - decode side
//                count/full/empty            - queue occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_fetch_queue
    import pipeline_fetch_queue_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_valid,
    input  logic [ADDR_W-1:0]        start_addr,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_addr,
    input  logic                     halt,
    output logic [ADDR_W-1:0]        imem_addr,
    output logic                     imem_req,
    input  logic [INSTR_W-1:0]       imem_rdata,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [INSTR_W-1:0]       deq_instr,
    output logic [ADDR_W-1:0]        deq_pc_plus4,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int ENTRY_W = INSTR_W + ADDR_W;

    run_state_e         state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_plus4;
    logic               deq_fire;
    logic               redirect_take;
    logic               flush;
    logic               enq;
    logic [ENTRY_W-1:0] head_entry;

    assign pc_plus4      = pc_q + ADDR_W'(4);
    assign deq_valid     = ~empty;
    assign deq_fire      = deq_valid & deq_ready;
    // Redirects only matter once a program has been started
    assign redirect_take = redirect_valid & (state_q != ST_IDLE);
    assign flush         = start_valid | redirect_take;
    // A full queue still accepts a fetch when its head leaves this cycle
    assign enq           = (state_q == ST_RUN) & ~redirect_valid & ~start_valid
                         & ~halt & (~full | deq_fire);

    assign imem_req  = enq;
    assign imem_addr = pc_q;

    // Run-state FSM and PC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
        end else if (start_valid) begin
            state_q <= ST_RUN;
            pc_q    <= start_addr;
        end else if (redirect_take) begin
            pc_q    <= redirect_addr;
        end else begin
            if (halt && state_q == ST_RUN) begin
                state_q <= ST_HALTED;
            end
            if (enq) begin
                pc_q <= pc_plus4;
            end
        end
    end

    pipeline_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (enq),
        .wdata_i ({imem_rdata, pc_plus4}),
        .pop_i   (deq_fire),
        .flush_i (flush),
        .rdata_o (head_entry),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign deq_instr    = head_entry[ENTRY_W-1:ADDR_W];
    assign deq_pc_plus4 = head_entry[ADDR_W-1:0];

endmodule : pipeline_fetch_queue
`default_nettype wire

// File: tb/tb_pipeline_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_fetch_queue
//  Description : Self-checking bench for pipeline_fetch_queue. A behavioural
//                model tracks run state, PC and a scoreboard queue of fetched
//                entries; entries are pushed on predicted fetches and popped
//                and compared when decode takes the head.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_fetch_queue;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [1:0] M_IDLE = 2'd0, M_RUN = 2'd1, M_HALT = 2'd2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start_valid;
    logic [ADDR_W-1:0]  start_addr;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_addr;
    logic               halt;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_req;
    logic [INSTR_W-1:0] imem_rdata;
    logic               deq_valid;
    logic               deq_ready;
    logic [INSTR_W-1:0] deq_instr;
    logic [ADDR_W-1:0]  deq_pc_plus4;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               empty;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0]                m_state;
    logic [ADDR_W-1:0]         m_pc;
    logic [INSTR_W+ADDR_W-1:0] sb [$];

    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    pipeline_fetch_queue #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_valid    (start_valid),
        .start_addr     (start_addr),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .halt           (halt),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .imem_rdata     (imem_rdata),
        .deq_valid      (deq_valid),
        .deq_ready      (deq_ready),
        .deq_instr      (deq_instr),
        .deq_pc_plus4   (deq_pc_plus4),
        .count          (count),
        .full           (full),
        .empty          (empty)
    );

    // One clock cycle: called just after a falling edge with inputs set.
    // Compares DUT against the model, advances the model across the rising
    // edge, and returns at the next falling edge.
    task automatic step();
        logic m_full, m_deq, m_enq;
        #1;
        m_full = (sb.size() == DEPTH);
        m_deq  = (sb.size() != 0) && deq_ready;
        m_enq  = (m_state == M_RUN) && !redirect_valid && !start_valid && !halt
                 && (!m_full || m_deq);
        n_tests++;
        if (deq_valid !== (sb.size() != 0)) begin
            n_fail++;
            $display("FAIL sb_deq_valid: got %b want %b", deq_valid, sb.size() != 0);
        end
        n_tests++;
        if (imem_req !== m_enq) begin
            n_fail++;
            $display("FAIL sb_imem_req: got %b want %b", imem_req, m_enq);
        end
        n_tests++;
        if (imem_addr !== m_pc) begin
            n_fail++;
            $display("FAIL sb_imem_addr: got %h want %h", imem_addr, m_pc);
        end
        n_tests++;
        if (count !== CNT_W'(sb.size())) begin
            n_fail++;
            $display("FAIL sb_count: got %0d want %0d", count, sb.size());
        end
        if (m_deq) begin
            n_tests++;
            if ({deq_instr, deq_pc_plus4} !== sb[0]) begin
                n_fail++;
                $display("FAIL sb_head: got %h/%h want %h/%h", deq_instr, deq_pc_plus4,
                         sb[0][INSTR_W+ADDR_W-1:ADDR_W], sb[0][ADDR_W-1:0]);
            end
        end
        @(posedge clk);
        if (start_valid) begin
            m_pc    = start_addr;
            m_state = M_RUN;
            sb.delete();
        end else if (redirect_valid && m_state != M_IDLE) begin
            m_pc = redirect_addr;
            sb.delete();
        end else begin
            if (halt && m_state == M_RUN) m_state = M_HALT;
            if (m_deq) void'(sb.pop_front());
            if (m_enq) begin
                sb.push_back({mem_word(m_pc), m_pc + 32'd4});
                m_pc = m_pc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        start_valid    = 1'b0;
        start_addr     = '0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        halt           = 1'b0;
        deq_ready      = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        m_state = M_IDLE;
        m_pc    = '0;
        sb.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_imem_req: got %b want 0", imem_req); end
        n_tests++; if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL rst_deq_valid: got %b want 0", deq_valid); end
        n_tests++; if (count !== '0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", count); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b want 1", empty); end
        n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b want 0", full); end
        n_tests++; if (imem_addr !== '0) begin n_fail++; $display("FAIL rst_imem_addr: got %h want 0", imem_addr); end
        n_tests++; if (deq_instr !== '0 || deq_pc_plus4 !== '0) begin
            n_fail++; $display("FAIL rst_head: got %h/%h want 0/0", deq_instr, deq_pc_plus4);
        end
        do_reset();
        @(negedge clk);
    endtask

    task automatic test_idle_redirect();
        redirect_valid = 1'b1;
        redirect_addr  = 32'h40;
        deq_ready      = 1'b1;
        step();
        step();
        clear_inputs();
        n_tests++; if (imem_addr !== '0) begin n_fail++; $display("FAIL idle_redirect_pc: got %h want 0", imem_addr); end
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_redirect_req: got %b want 0", imem_req); end
    endtask

    task automatic test_start();
        start_valid = 1'b1;
        start_addr  = 32'h100;
        step();
        start_valid = 1'b0;
        deq_ready   = 1'b1;
        n_tests++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL start_pc: got %h want 100", imem_addr); end
        n_tests++; if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL start_no_bypass: got %b want 0", deq_valid); end
        step();
        n_tests++; if (imem_addr !== 32'h104) begin n_fail++; $display("FAIL start_pc2: got %h want 104", imem_addr); end
        n_tests++; if (deq_valid !== 1'b1 || deq_pc_plus4 !== 32'h104) begin
            n_fail++; $display("FAIL start_head: got %b/%h want 1/104", deq_valid, deq_pc_plus4);
        end
        repeat (5) step();
        clear_inputs();
    endtask

    task automatic test_fill();
        do_reset();
        start_valid = 1'b1;
        start_addr  = 32'h100;
        step();
        start_valid = 1'b0;
        repeat (4) step();
        n_tests++; if (count !== CNT_W'(4) || full !== 1'b1) begin
            n_fail++; $display("FAIL fill_full: got count %0d full %b want 4/1", count, full);
        end
        n_tests++; if (imem_addr !== 32'h110) begin n_fail++; $display("FAIL fill_pc: got %h want 110", imem_addr); end
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL fill_req: got %b want 0", imem_req); end
        step();
        n_tests++; if (imem_addr !== 32'h110) begin n_fail++; $display("FAIL fill_pc_hold: got %h want 110", imem_addr); end
    endtask

    task automatic test_full_deq();
        deq_ready = 1'b1;
        #1;
        n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL fulldeq_req: got %b want 1", imem_req); end
        step();
        deq_ready = 1'b0;
        n_tests++; if (count !== CNT_W'(4) || full !== 1'b1) begin
            n_fail++; $display("FAIL fulldeq_count: got %0d want 4", count);
        end
        n_tests++; if (imem_addr !== 32'h114) begin n_fail++; $display("FAIL fulldeq_pc: got %h want 114", imem_addr); end
        n_tests++; if (deq_pc_plus4 !== 32'h108) begin n_fail++; $display("FAIL fulldeq_head: got %h want 108", deq_pc_plus4); end
        step();
    endtask

    task automatic test_redirect();
        do_reset();
        start_valid = 1'b1;
        start_addr  = 32'h100;
        step();
        start_valid = 1'b0;
        repeat (3) step();
        n_tests++; if (count !== CNT_W'(3)) begin n_fail++; $display("FAIL redir_pre_count: got %0d want 3", count); end
        redirect_valid = 1'b1;
        redirect_addr  = 32'h200;
        step();
        redirect_valid = 1'b0;
        n_tests++; if (count !== '0 || empty !== 1'b1) begin
            n_fail++; $display("FAIL redir_flush: got count %0d empty %b want 0/1", count, empty);
        end
        n_tests++; if (imem_addr !== 32'h200) begin n_fail++; $display("FAIL redir_pc: got %h want 200", imem_addr); end
        deq_ready = 1'b1;
        step();
        n_tests++; if (deq_pc_plus4 !== 32'h204 || deq_instr !== mem_word(32'h200)) begin
            n_fail++; $display("FAIL redir_head: got %h/%h want %h/204", deq_instr, deq_pc_plus4, mem_word(32'h200));
        end
        repeat (3) step();
        clear_inputs();
    endtask

    task automatic test_halt();
        do_reset();
        start_valid = 1'b1;
        start_addr  = 32'h104;
        step();
        start_valid = 1'b0;
        repeat (2) step();
        n_tests++; if (imem_addr !== 32'h10C || count !== CNT_W'(2)) begin
            n_fail++; $display("FAIL halt_pre: got pc %h count %0d want 10c/2", imem_addr, count);
        end
        halt = 1'b1;
        step();
        halt      = 1'b0;
        deq_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL halt_req: got %b want 0", imem_req); end
            step();
        end
        n_tests++; if (empty !== 1'b1 || imem_addr !== 32'h10C) begin
            n_fail++; $display("FAIL halt_drain: got empty %b pc %h want 1/10c", empty, imem_addr);
        end
        start_valid = 1'b1;
        start_addr  = 32'h300;
        step();
        start_valid = 1'b0;
        #1;
        n_tests++; if (imem_addr !== 32'h300 || imem_req !== 1'b1) begin
            n_fail++; $display("FAIL halt_restart: got pc %h req %b want 300/1", imem_addr, imem_req);
        end
        repeat (3) step();
        clear_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        start_valid = 1'b1;
        start_addr  = 32'h100;
        step();
        start_valid = 1'b0;
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (deq_valid !== 1'b0 || count !== '0 || empty !== 1'b1) begin
            n_fail++; $display("FAIL async_rst: got valid %b count %0d empty %b want 0/0/1", deq_valid, count, empty);
        end
        n_tests++; if (imem_addr !== '0) begin n_fail++; $display("FAIL async_rst_pc: got %h want 0", imem_addr); end
        m_state = M_IDLE;
        m_pc    = '0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_wrap();
        do_reset();
        start_valid = 1'b1;
        start_addr  = 32'hFFFF_FFFC;
        step();
        start_valid = 1'b0;
        deq_ready   = 1'b1;
        step();
        n_tests++; if (imem_addr !== 32'h0 || deq_pc_plus4 !== 32'h0) begin
            n_fail++; $display("FAIL wrap: got pc %h head %h want 0/0", imem_addr, deq_pc_plus4);
        end
        repeat (2) step();
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        start_valid = 1'b1;
        start_addr  = 32'hFFFF_FFF0;
        step();
        for (int i = 0; i < 400; i++) begin
            start_valid    = ($urandom_range(0, 120) == 0);
            start_addr     = $urandom & 32'hFFFF_FFFC;
            redirect_valid = ($urandom_range(0, 30) == 0);
            redirect_addr  = $urandom & 32'hFFFF_FFFC;
            halt           = ($urandom_range(0, 150) == 0);
            deq_ready      = ($urandom_range(0, 3) != 0);
            step();
        end
        clear_inputs();
        deq_ready = 1'b1;
        repeat (6) step();
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_n   = 1'b0;
        m_state = M_IDLE;
        m_pc    = '0;
        @(negedge clk);
        test_reset();
        test_idle_redirect();
        test_start();
        test_fill();
        test_full_deq();
        test_redirect();
        test_halt();
        test_async_reset();
        test_wrap();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pipeline_fetch_queue
`default_nettype wire
